// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// Signals: req/we/addr/wdata/be out of the master; ready/rdata back.
interface mem_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic [3:0]            dmem_be;
  logic                  dmem_ready;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: loads, stores, LR/SC and read-modify-write AMOs on dmem.
// Ports: clk/rst, EX-side request fields, dmem bus, rdata/done/stall/misaligned.
module mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [2:0]            lsuop,
  input  logic                  ld_en,
  input  logic                  dm_en,
  input  logic                  amo_en,
  input  logic [3:0]            amoop,
  mem_stage_if.master           dmem,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  stall,
  output logic                  misaligned
);
  typedef enum logic {IDLE, AMO_WR} state_t;

  state_t                state_q, state_d;
  logic                  resv_valid_q;
  logic [ADDR_WIDTH-3:0] resv_addr_q;
  logic [DATA_WIDTH-1:0] amo_old_q, amo_new_q;
  logic [DATA_WIDTH-1:0] amo_res;
  logic [DATA_WIDTH-1:0] ld_ext, st_data, rd_sh;
  logic [3:0]            be_c;
  logic [4:0]            sh;
  logic                  sel, mis_c, hit, is_lr, is_sc;
  logic                  resv_set, resv_clr, amo_lat;

  assign sel   = valid_in & (ld_en | dm_en | amo_en);
  assign sh    = {addr[1:0], 3'b000};
  assign hit   = resv_valid_q
               & (resv_addr_q == addr[ADDR_WIDTH-1:2]);
  assign is_lr = amo_en & (amoop == 4'd0);
  assign is_sc = amo_en & (amoop == 4'd1);
  assign mis_c = amo_en ? (addr[1:0] != 2'b00)
               : ((lsuop[1:0] == 2'b01) & addr[0])
               | ((lsuop[1:0] == 2'b10) & (addr[1:0] != 2'b00));

  assign dmem.dmem_addr = {addr[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    rd_sh   = dmem.dmem_rdata >> sh;
    ld_ext  = dmem.dmem_rdata;
    st_data = wdata;
    be_c    = 4'b1111;
    unique case (lsuop)
      3'b000: ld_ext = {{(DATA_WIDTH-8){rd_sh[7]}}, rd_sh[7:0]};
      3'b001: ld_ext = {{(DATA_WIDTH-16){rd_sh[15]}}, rd_sh[15:0]};
      3'b100: ld_ext = {{(DATA_WIDTH-8){1'b0}}, rd_sh[7:0]};
      3'b101: ld_ext = {{(DATA_WIDTH-16){1'b0}}, rd_sh[15:0]};
      default: ld_ext = dmem.dmem_rdata;
    endcase
    unique case (lsuop[1:0])
      2'b00: begin
        st_data = {{(DATA_WIDTH-8){1'b0}}, wdata[7:0]} << sh;
        be_c    = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_data = {{(DATA_WIDTH-16){1'b0}}, wdata[15:0]} << sh;
        be_c    = 4'b0011 << addr[1:0];
      end
      default: begin
        st_data = wdata;
        be_c    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    unique case (amoop)
      4'd3:  amo_res = dmem.dmem_rdata + wdata;
      4'd4:  amo_res = dmem.dmem_rdata ^ wdata;
      4'd5:  amo_res = dmem.dmem_rdata & wdata;
      4'd6:  amo_res = dmem.dmem_rdata | wdata;
      4'd7:  amo_res = ($signed(dmem.dmem_rdata) < $signed(wdata))
                     ? dmem.dmem_rdata : wdata;
      4'd8:  amo_res = ($signed(dmem.dmem_rdata) > $signed(wdata))
                     ? dmem.dmem_rdata : wdata;
      4'd9:  amo_res = (dmem.dmem_rdata < wdata)
                     ? dmem.dmem_rdata : wdata;
      4'd10: amo_res = (dmem.dmem_rdata > wdata)
                     ? dmem.dmem_rdata : wdata;
      default: amo_res = wdata;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_be    = 4'b0000;
    dmem.dmem_wdata = '0;
    rdata           = '0;
    done            = 1'b0;
    misaligned      = 1'b0;
    resv_set        = 1'b0;
    resv_clr        = 1'b0;
    amo_lat         = 1'b0;
    if (state_q == AMO_WR) begin
      dmem.dmem_req   = 1'b1;
      dmem.dmem_we    = 1'b1;
      dmem.dmem_be    = 4'b1111;
      dmem.dmem_wdata = amo_new_q;
      if (dmem.dmem_ready) begin
        done     = 1'b1;
        rdata    = amo_old_q;
        resv_clr = hit;
        state_d  = IDLE;
      end
    end else if (sel) begin
      if (mis_c) begin
        done       = 1'b1;
        misaligned = 1'b1;
      end else if (ld_en) begin
        dmem.dmem_req = 1'b1;
        dmem.dmem_be  = be_c;
        if (dmem.dmem_ready) begin
          done  = 1'b1;
          rdata = ld_ext;
        end
      end else if (dm_en) begin
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = 1'b1;
        dmem.dmem_be    = be_c;
        dmem.dmem_wdata = st_data;
        if (dmem.dmem_ready) begin
          done     = 1'b1;
          resv_clr = hit;
        end
      end else if (is_lr) begin
        dmem.dmem_req = 1'b1;
        dmem.dmem_be  = 4'b1111;
        if (dmem.dmem_ready) begin
          done     = 1'b1;
          rdata    = dmem.dmem_rdata;
          resv_set = 1'b1;
        end
      end else if (is_sc) begin
        if (hit) begin
          dmem.dmem_req   = 1'b1;
          dmem.dmem_we    = 1'b1;
          dmem.dmem_be    = 4'b1111;
          dmem.dmem_wdata = wdata;
          if (dmem.dmem_ready) begin
            done     = 1'b1;
            resv_clr = 1'b1;
          end
        end else begin
          done     = 1'b1;
          rdata    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
          resv_clr = 1'b1;
        end
      end else begin
        // read half of a read-modify-write AMO
        dmem.dmem_req = 1'b1;
        dmem.dmem_be  = 4'b1111;
        if (dmem.dmem_ready) begin
          amo_lat = 1'b1;
          state_d = AMO_WR;
        end
      end
    end
    if (rst) begin
      dmem.dmem_req = 1'b0;
      dmem.dmem_we  = 1'b0;
      rdata         = '0;
      done          = 1'b0;
      misaligned    = 1'b0;
    end
  end

  assign stall = sel & ~done & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
      amo_old_q    <= '0;
      amo_new_q    <= '0;
    end else begin
      state_q <= state_d;
      if (resv_set) begin
        resv_valid_q <= 1'b1;
        resv_addr_q  <= addr[ADDR_WIDTH-1:2];
      end else if (resv_clr) begin
        resv_valid_q <= 1'b0;
      end
      if (amo_lat) begin
        amo_old_q <= dmem.dmem_rdata;
        amo_new_q <= amo_res;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a small memory responder.
// Responder raises dmem_ready after ready_delay wait cycles per request.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  lsuop;
  logic        ld_en, dm_en, amo_en;
  logic [3:0]  amoop;
  logic        done, stall, misaligned;

  int errors = 0;
  int checks = 0;
  int ready_delay = 0;
  int wait_cnt = 0;
  int req_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [31:0] mem [0:1023];

  mem_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dif ();

  mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .addr(addr),
    .wdata(wdata), .lsuop(lsuop), .ld_en(ld_en), .dm_en(dm_en),
    .amo_en(amo_en), .amoop(amoop), .dmem(dif.master),
    .rdata(rdata), .done(done), .stall(stall),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  assign dif.dmem_ready = dif.dmem_req && (wait_cnt >= ready_delay);
  assign dif.dmem_rdata = mem[dif.dmem_addr[11:2]];

  always @(posedge clk) begin
    if (dif.dmem_req) req_cnt <= req_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (dif.dmem_req && dif.dmem_ready) begin
      wait_cnt <= 0;
      if (dif.dmem_we) begin
        wr_cnt <= wr_cnt + 1;
        for (int b = 0; b < 4; b++)
          if (dif.dmem_be[b])
            mem[dif.dmem_addr[11:2]][8*b +: 8] <= dif.dmem_wdata[8*b +: 8];
      end
    end else if (dif.dmem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic idle_inputs();
    valid_in = 1'b0;
    addr = '0; wdata = '0; lsuop = 3'b010;
    ld_en = 1'b0; dm_en = 1'b0; amo_en = 1'b0; amoop = 4'd0;
  endtask

  // Drive one op from a negedge; collect outputs of the done cycle.
  task automatic run_op(
    input  logic [31:0] a, input logic [31:0] wd, input logic [2:0] op,
    input  logic l, input logic s, input logic m, input logic [3:0] ao,
    output logic [31:0] r, output int st, output logic mi,
    output logic [3:0] be_o, output logic [31:0] wd_o
  );
    logic got;
    got = 1'b0; st = 0; r = 'x; mi = 1'bx; be_o = 'x; wd_o = 'x;
    addr = a; wdata = wd; lsuop = op;
    ld_en = l; dm_en = s; amo_en = m; amoop = ao; valid_in = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      #1;
      if (done) begin
        r = rdata; mi = misaligned;
        be_o = dif.dmem_be; wd_o = dif.dmem_wdata;
        got = 1'b1;
      end else if (stall) begin
        st++;
      end
      @(negedge clk);
    end
    idle_inputs();
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout: no done for addr %h", a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    valid_in = 1'b1; ld_en = 1'b1; addr = 32'h100;
    #1;
    checks++;
    if ({dif.dmem_req, stall, done, misaligned} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: got %b exp 0000",
               {dif.dmem_req, stall, done, misaligned});
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h exp 0", rdata);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_lw_wait();
    logic [31:0] r, wdo; int st; logic mi; logic [3:0] be;
    ready_delay = 2;
    mem[32'h100 >> 2] = 32'h8000_00F0;
    run_op(32'h100, 0, 3'b010, 1, 0, 0, 0, r, st, mi, be, wdo);
    checks++;
    if (r !== 32'h8000_00F0) begin
      errors++; $display("FAIL lw_rdata: got %h exp 800000f0", r);
    end
    checks++;
    if (st !== 2) begin
      errors++; $display("FAIL lw_stall: got %0d exp 2", st);
    end
    ready_delay = 0;
  endtask

  task automatic test_byte_half();
    logic [31:0] r, wdo; int st; logic mi; logic [3:0] be;
    mem[32'h100 >> 2] = 32'h8000_0000;
    run_op(32'h103, 0, 3'b000, 1, 0, 0, 0, r, st, mi, be, wdo);
    checks++;
    if (r !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb: got %h exp ffffff80", r);
    end
    run_op(32'h103, 0, 3'b100, 1, 0, 0, 0, r, st, mi, be, wdo);
    checks++;
    if (r !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu: got %h exp 00000080", r);
    end
    mem[32'h100 >> 2] = 32'h1234_5678;
    run_op(32'h102, 32'h0000_ABCD, 3'b001, 0, 1, 0, 0,
           r, st, mi, be, wdo);
    checks++;
    if (be !== 4'b1100) begin
      errors++; $display("FAIL sh_be: got %b exp 1100", be);
    end
    checks++;
    if (wdo !== 32'hABCD_0000) begin
      errors++; $display("FAIL sh_wdata: got %h exp abcd0000", wdo);
    end
    checks++;
    if (mem[32'h100 >> 2] !== 32'hABCD_5678) begin
      errors++;
      $display("FAIL sh_mem: got %h exp abcd5678", mem[32'h100 >> 2]);
    end
    mem[32'h100 >> 2] = 32'h0000_8000;
    run_op(32'h100, 0, 3'b001, 1, 0, 0, 0, r, st, mi, be, wdo);
    checks++;
    if (r !== 32'hFFFF_8000) begin
      errors++; $display("FAIL lh: got %h exp ffff8000", r);
    end
  endtask

  task automatic test_amo();
    logic [31:0] r, wdo; int st; logic mi; logic [3:0] be;
    int d0, w0;
    mem[32'h200 >> 2] = 32'd5;
    d0 = done_cnt; w0 = wr_cnt;
    run_op(32'h200, 32'd3, 3'b010, 0, 0, 1, 4'd3, r, st, mi, be, wdo);
    @(negedge clk);
    checks++;
    if (r !== 32'd5) begin
      errors++; $display("FAIL amoadd_rdata: got %h exp 5", r);
    end
    checks++;
    if (mem[32'h200 >> 2] !== 32'd8) begin
      errors++;
      $display("FAIL amoadd_mem: got %h exp 8", mem[32'h200 >> 2]);
    end
    checks++;
    if (done_cnt - d0 !== 1 || wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL amoadd_once: done %0d wr %0d exp 1 1",
               done_cnt - d0, wr_cnt - w0);
    end
    mem[32'h200 >> 2] = 32'hFFFF_FFFF;
    run_op(32'h200, 32'd1, 3'b010, 0, 0, 1, 4'd7, r, st, mi, be, wdo);
    checks++;
    if (mem[32'h200 >> 2] !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL amomin: got %h exp ffffffff", mem[32'h200 >> 2]);
    end
    mem[32'h200 >> 2] = 32'hFFFF_FFFF;
    ready_delay = 1;
    run_op(32'h200, 32'd1, 3'b010, 0, 0, 1, 4'd9, r, st, mi, be, wdo);
    ready_delay = 0;
    checks++;
    if (mem[32'h200 >> 2] !== 32'd1 || r !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL amominu: mem %h r %h exp 1 ffffffff",
               mem[32'h200 >> 2], r);
    end
    mem[32'h200 >> 2] = 32'h0000_0010;
    run_op(32'h200, 32'hFFFF_FFF0, 3'b010, 0, 0, 1, 4'd8,
           r, st, mi, be, wdo);
    checks++;
    if (mem[32'h200 >> 2] !== 32'h0000_0010) begin
      errors++;
      $display("FAIL amomax: got %h exp 10", mem[32'h200 >> 2]);
    end
  endtask

  task automatic test_lr_sc();
    logic [31:0] r, wdo; int st; logic mi; logic [3:0] be;
    int q0;
    mem[32'h300 >> 2] = 32'h11;
    run_op(32'h300, 0, 3'b010, 0, 0, 1, 4'd0, r, st, mi, be, wdo);
    checks++;
    if (r !== 32'h11) begin
      errors++; $display("FAIL lr_rdata: got %h exp 11", r);
    end
    run_op(32'h300, 32'h22, 3'b010, 0, 0, 1, 4'd1, r, st, mi, be, wdo);
    checks++;
    if (r !== 32'h0 || mem[32'h300 >> 2] !== 32'h22) begin
      errors++;
      $display("FAIL sc_ok: r %h mem %h exp 0 22", r, mem[32'h300 >> 2]);
    end
    q0 = req_cnt;
    run_op(32'h300, 32'h33, 3'b010, 0, 0, 1, 4'd1, r, st, mi, be, wdo);
    checks++;
    if (r !== 32'h1 || req_cnt !== q0 || mem[32'h300 >> 2] !== 32'h22) begin
      errors++;
      $display("FAIL sc_fail: r %h reqs %0d mem %h exp 1 0 22",
               r, req_cnt - q0, mem[32'h300 >> 2]);
    end
    run_op(32'h300, 0, 3'b010, 0, 0, 1, 4'd0, r, st, mi, be, wdo);
    run_op(32'h300, 32'h44, 3'b010, 0, 1, 0, 0, r, st, mi, be, wdo);
    run_op(32'h300, 32'h55, 3'b010, 0, 0, 1, 4'd1, r, st, mi, be, wdo);
    checks++;
    if (r !== 32'h1 || mem[32'h300 >> 2] !== 32'h44) begin
      errors++;
      $display("FAIL sc_after_sw: r %h mem %h exp 1 44",
               r, mem[32'h300 >> 2]);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] r, wdo; int st; logic mi; logic [3:0] be;
    int q0;
    q0 = req_cnt;
    run_op(32'h101, 0, 3'b010, 1, 0, 0, 0, r, st, mi, be, wdo);
    checks++;
    if (mi !== 1'b1 || r !== 32'h0 || st !== 0 || req_cnt !== q0) begin
      errors++;
      $display("FAIL misaligned: mis %b r %h st %0d reqs %0d exp 1 0 0 0",
               mi, r, st, req_cnt - q0);
    end
  endtask

  task automatic test_no_select();
    valid_in = 1'b1;
    addr = 32'h100;
    #1;
    checks++;
    if ({dif.dmem_req, stall, done} !== 3'b000) begin
      errors++;
      $display("FAIL no_select: got %b exp 000",
               {dif.dmem_req, stall, done});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_amo();
    logic [31:0] r, wdo; int st; logic mi; logic [3:0] be;
    logic found;
    int w0;
    mem[32'h300 >> 2] = 32'h66;
    run_op(32'h300, 0, 3'b010, 0, 0, 1, 4'd0, r, st, mi, be, wdo);
    mem[32'h400 >> 2] = 32'd7;
    w0 = wr_cnt;
    ready_delay = 3;
    addr = 32'h400; wdata = 32'd1; lsuop = 3'b010;
    amo_en = 1'b1; amoop = 4'd3; valid_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (dif.dmem_we) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL amo_wr_phase: got 0 exp 1");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({dif.dmem_req, done, stall} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_amo: got %b exp 000",
               {dif.dmem_req, done, stall});
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    ready_delay = 0;
    @(negedge clk);
    checks++;
    if (mem[32'h400 >> 2] !== 32'd7 || wr_cnt !== w0) begin
      errors++;
      $display("FAIL rst_no_write: mem %h wr %0d exp 7 0",
               mem[32'h400 >> 2], wr_cnt - w0);
    end
    run_op(32'h300, 32'h77, 3'b010, 0, 0, 1, 4'd1, r, st, mi, be, wdo);
    checks++;
    if (r !== 32'h1 || mem[32'h300 >> 2] !== 32'h66) begin
      errors++;
      $display("FAIL rst_resv: r %h mem %h exp 1 66",
               r, mem[32'h300 >> 2]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_lw_wait();
    test_byte_half();
    test_amo();
    test_lr_sc();
    test_misaligned();
    test_no_select();
    test_reset_mid_amo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath and memory data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, data-memory byte address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port valid_in  input  1  memory-class instruction present; held stable by upstream while stall=1.
REQ-006 SHALL have port addr  input  ADDR_WIDTH  effective address (EX opr_res).
REQ-007 SHALL have port wdata  input  DATA_WIDTH  store/AMO source data (EX forwarded opr_b).
REQ-008 SHALL have port lsuop  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port ld_en, dm_en, amo_en  input  1 each  load, store, atomic select; at most one set.
REQ-010 SHALL have port amoop  input  4  0 LR,1 SC,2 SWAP,3 ADD,4 XOR,5 AND,6 OR,7 MIN,8 MAX,9 MINU,10 MAXU.
REQ-011 SHALL have ports dmem_req, dmem_we  output  1 each  memory request, write enable.
REQ-012 SHALL have ports dmem_addr  output  ADDR_WIDTH (word-aligned), dmem_wdata  output  DATA_WIDTH, dmem_be  output  4.
REQ-013 SHALL have ports dmem_ready  input  1 (request accepted; read data valid same cycle) and dmem_rdata  input  DATA_WIDTH.
REQ-014 SHALL have ports rdata  output  DATA_WIDTH  result to WB; done  output  1  final cycle of operation; stall  output  1  freeze upstream; misaligned  output  1  alignment fault.

Function
REQ-015 SHALL implement FSM states IDLE, AMO_WR; loads, stores, LR, SC complete from IDLE.
REQ-016 SHALL assert stall = valid_in & (ld_en|dm_en|amo_en) & ~done, combinationally.
REQ-017 SHALL, in IDLE with valid load/store/LR, assert dmem_req each cycle until dmem_ready=1; done in that ready cycle.
REQ-018 SHALL shift store data to byte lane addr[1:0] and drive dmem_be: B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111.
REQ-019 SHALL extract load byte/half from lane addr[1:0], sign-extend for B/H, zero-extend for BU/HU.
REQ-020 SHALL flag misaligned (H with addr[0]=1; W/all AMO with addr[1:0]!=0): no dmem_req, done=1 and misaligned=1 same cycle, rdata=0.
REQ-021 SHALL for AMO ops 2-10 read in IDLE; on ready latch old value, compute new value, go AMO_WR (no done).
REQ-022 SHALL in AMO_WR drive dmem_req=1, dmem_we=1, be=1111, wdata=computed value until ready; then done=1, rdata=latched old value, return IDLE.
REQ-023 SHALL compute MIN/MAX signed, MINU/MAXU unsigned, ADD modulo 2^DATA_WIDTH.
REQ-024 SHALL on LR completion set reservation valid with word address addr[ADDR_WIDTH-1:2].
REQ-025 SHALL on SC with valid matching reservation perform word write, rdata=0; otherwise no request, done same cycle, rdata=1.
REQ-026 SHALL clear the reservation on every SC (success or fail) and on any completed store/AMO write to the reserved word.
REQ-027 SHALL hold rdata valid only in done cycle; done is a single-cycle pulse per instruction.
REQ-028 SHALL ignore valid_in with no select set: no request, stall=0, done=0.

Reset
REQ-029 SHALL while rst=1 force dmem_req=0, done=0, stall=0, misaligned=0, rdata=0.
REQ-030 SHALL on reset edge enter IDLE, clear reservation and latched AMO data, including mid-AMO abort without write.

Verification
REQ-031 LW addr=0x100, dmem_ready after 2 wait cycles, rdata_in=0x8000_00F0 -> stall 2 cycles, done cycle 3, rdata=0x8000_00F0.
REQ-032 LB addr=0x103, dmem_rdata=0x8000_0000 -> rdata=0xFFFF_FF80; LBU -> 0x0000_0080; SH addr=0x102 wdata=0xABCD -> be=1100, dmem_wdata=0xABCD_0000.
REQ-033 AMOADD addr=0x200, mem=5, wdata=3 -> read then write 8, rdata=5, done once; AMOMIN mem=0xFFFF_FFFF wdata=1 -> write 0xFFFF_FFFF; AMOMINU -> write 1.
REQ-034 LR 0x300, SC 0x300 -> SC write, rdata=0; second SC 0x300 -> no request, rdata=1; LR 0x300, SW 0x300, SC -> rdata=1.
REQ-035 LW addr=0x101 -> misaligned=1, done=1, no dmem_req; rst=1 during AMO_WR -> no write, IDLE, reservation cleared.
